decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   RV32I decode stage directly downstream of instruction fetch. Accepts (pc, instruction) beats over a
//   valid/ready handshake and extracts register indices, funct fields, opcode, sign-extended immediate
//   and an illegal flag. Presents the registered bundle to execute over a second valid/ready handshake.
//   A 2-entry buffer (output register + skid register) gives full throughput under backpressure.
//   Writeback can flush all in-flight beats on a PC redirect.
// PARAMETERS
//   XLEN       32             datapath width; pc, instruction and immediate width
//   NOP_INSTR  32'h0000_0013  value driven on decode_execute_instruction while invalid or in reset
// PORTS
//   clk                         in   1     clock, rising edge
//   rst_n                       in   1     asynchronous, active-low reset
//   ifetch_decode_valid         in   1     fetch beat valid
//   ifetch_decode_ready         out  1     decode can accept a beat
//   ifetch_decode_pc            in   XLEN  pc of the fetched instruction
//   ifetch_decode_instruction   in   XLEN  raw instruction word
//   writeback_decode_flush      in   1     discard every held and incoming beat (redirect)
//   decode_execute_valid        out  1     decoded bundle valid
//   decode_execute_ready        in   1     execute accepts the bundle
//   decode_execute_pc           out  XLEN  pc of the bundle
//   decode_execute_instruction  out  XLEN  raw instruction word
//   decode_execute_opcode       out  7     instr[6:0]
//   decode_execute_rd           out  5     instr[11:7]
//   decode_execute_rs1          out  5     instr[19:15]
//   decode_execute_rs2          out  5     instr[24:20]
//   decode_execute_funct3       out  3     instr[14:12]
//   decode_execute_funct7       out  7     instr[31:25]
//   decode_execute_imm          out  XLEN  sign-extended immediate; 0 for OP and illegal encodings
//   decode_execute_illegal      out  1     unsupported or illegal encoding
// BEHAVIOUR
//   - Reset (rst_n low, async): out_valid=0, skid_valid=0, all data registers 0, and
//     instruction = NOP_INSTR. Registers are held in reset until the first clk edge after rst_n rises.
//   - ifetch_decode_ready = !skid_valid (registered, no combinational path from decode_execute_ready).
//   - Accept = ifetch_decode_valid & ifetch_decode_ready. Decode is combinational on the input.
//   - Latency: the decoded bundle appears on the outputs the cycle after acceptance.
//   - Fire_out = decode_execute_valid & decode_execute_ready. Buffer update, in priority order:
//       flush            -> out_valid=0, skid_valid=0; the beat accepted in this cycle is dropped.
//       skid_valid&fire  -> out <= skid; skid <= accepted beat if any, else skid_valid=0.
//       !out_valid|fire  -> out <= accepted beat (out_valid=accept).
//       else if accept   -> skid <= accepted beat, skid_valid=1.
//   - Beats leave in acceptance order. None is lost or duplicated. Holding valid is the producer's job.
//   - Outputs are stable while decode_execute_valid=1 and ready=0.
//   - While out_valid=0, data outputs hold their last values, except instruction, which is NOP_INSTR.
//   - Immediate formats, selected by opcode:
//       I-type: 0000011, 0001111, 0010011, 1100111, 1110011
//       S-type: 0100011
//       B-type: 1100011 (bit0=0)
//       U-type: 0110111, 0010111 (low 12 bits 0)
//       J-type: 1101111 (bit0=0)
//       none:   0110011 (imm=0)
//   - Sign extension comes from instr[31] in all formats.
//   - illegal=1 when instr[1:0]!=2'b11 or the opcode is not in the list above. The beat is still
//     passed downstream with imm=0.
//   - Flush during reset-release or with an empty buffer is harmless. Flush and accept in the same
//     cycle leave the buffer empty.
// TESTING
//   1. 0x00500093 @pc 0x80 (addi x1,x0,5) -> next cycle valid=1, opcode 0x13, rd=1, rs1=0, imm=5, illegal=0
//   2. 0xFE000EE3 (beq x0,x0,-4)          -> imm=0xFFFFFFFC, funct3=0
//      0x123450B7 (lui x1)                -> imm=0x12345000
//   3. decode_execute_ready=0 for 3 cycles, 3 back-to-back beats -> ifetch_decode_ready drops after beat 2;
//      on release beats emerge in order pc 0,4,8 with no gaps
//   4. 0x00000000 and 0xFFFFFFFF          -> illegal=1, imm=0, still valid
//   5. Both entries full + flush with a new beat presented -> next cycle valid=0, ready=1, and no beat
//      from before or during the flush ever appears
//   6. Assert rst_n low mid-stream between clk edges -> valid=0 and instruction=0x00000013 immediately;
//      after release the first accepted beat is decoded normally

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage sitting directly behind instruction fetch. Each accepted
//   (pc, instruction) beat is decoded combinationally into register indices,
//   funct fields, opcode, a sign-extended immediate and an illegal flag. The
//   decoded bundle is registered and offered to execute one cycle later.
//
//   A two-entry buffer (output register + skid register) keeps full throughput
//   under backpressure. The fetch-side ready therefore depends only on
//   registered state, never combinationally on execute's ready.
//
//   A writeback flush discards every held beat and any beat accepted in the
//   same cycle.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   ifetch_decode_*             fetch -> decode handshake: valid/ready, pc, instruction
//   writeback_decode_flush      drop all in-flight beats (pc redirect)
//   decode_execute_valid/ready  decode -> execute handshake
//   decode_execute_*            decoded bundle: pc, instruction, opcode, rd, rs1,
//                               rs2, funct3, funct7, imm, illegal
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifetch_decode_valid,
    output logic            ifetch_decode_ready,
    input  logic [XLEN-1:0] ifetch_decode_pc,
    input  logic [XLEN-1:0] ifetch_decode_instruction,
    input  logic            writeback_decode_flush,
    output logic            decode_execute_valid,
    input  logic            decode_execute_ready,
    output logic [XLEN-1:0] decode_execute_pc,
    output logic [XLEN-1:0] decode_execute_instruction,
    output logic [6:0]      decode_execute_opcode,
    output logic [4:0]      decode_execute_rd,
    output logic [4:0]      decode_execute_rs1,
    output logic [4:0]      decode_execute_rs2,
    output logic [2:0]      decode_execute_funct3,
    output logic [6:0]      decode_execute_funct7,
    output logic [XLEN-1:0] decode_execute_imm,
    output logic            decode_execute_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE, FMT_BAD
    } imm_fmt_e;

    logic [31:0] in_word;
    imm_fmt_e    fmt;
    logic [31:0] imm32;
    bundle_t     in_beat;

    bundle_t     out_q;
    bundle_t     skid_q;
    logic        out_valid_q;
    logic        skid_valid_q;

    logic        accept;
    logic        fire;

    assign in_word = ifetch_decode_instruction[31:0];

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming word
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case statements can leave it unassigned (no latch).
    always_comb begin
        fmt = FMT_BAD;
        case (in_word[6:0])
            7'b0000011, 7'b0001111, 7'b0010011,
            7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0100011:             fmt = FMT_S;
            7'b1100011:             fmt = FMT_B;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111:             fmt = FMT_J;
            7'b0110011:             fmt = FMT_NONE;
            // Anything else, including words whose low two bits are not 2'b11,
            // is not a supported 32-bit encoding.
            default:                fmt = FMT_BAD;
        endcase

        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{in_word[31]}}, in_word[31:20]};
            FMT_S:   imm32 = {{20{in_word[31]}}, in_word[31:25], in_word[11:7]};
            FMT_B:   imm32 = {{19{in_word[31]}}, in_word[31], in_word[7],
                              in_word[30:25], in_word[11:8], 1'b0};
            FMT_U:   imm32 = {in_word[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_word[31]}}, in_word[31], in_word[19:12],
                              in_word[20], in_word[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        in_beat         = '0;
        in_beat.pc      = ifetch_decode_pc;
        in_beat.instr   = ifetch_decode_instruction;
        in_beat.opcode  = in_word[6:0];
        in_beat.rd      = in_word[11:7];
        in_beat.rs1     = in_word[19:15];
        in_beat.rs2     = in_word[24:20];
        in_beat.funct3  = in_word[14:12];
        in_beat.funct7  = in_word[31:25];
        in_beat.imm     = XLEN'($signed(imm32));
        in_beat.illegal = (fmt == FMT_BAD);
    end

    // -------------------------------------------------------------------------
    // Two-entry buffer: output register plus skid register
    // -------------------------------------------------------------------------
    assign ifetch_decode_ready = !skid_valid_q;
    assign accept              = ifetch_decode_valid && !skid_valid_q;
    assign fire                = out_valid_q && decode_execute_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            out_q.instr  <= NOP_INSTR;
            skid_q       <= '0;
        end else if (writeback_decode_flush) begin
            // Redirect: everything held and anything accepted now is stale.
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q && fire) begin
            // The older skid beat moves up; a new beat refills the skid.
            out_q        <= skid_q;
            skid_valid_q <= accept;
            if (accept) begin
                skid_q <= in_beat;
            end
        end else if (!out_valid_q || fire) begin
            out_valid_q <= accept;
            if (accept) begin
                out_q <= in_beat;
            end
        end else if (accept) begin
            // Output register stalled: park the beat in the skid register.
            skid_q       <= in_beat;
            skid_valid_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: data holds its last value while invalid, except the instruction
    // word, which reads as a NOP so execute never sees a stale instruction.
    // -------------------------------------------------------------------------
    assign decode_execute_valid       = out_valid_q;
    assign decode_execute_pc          = out_q.pc;
    assign decode_execute_instruction = out_valid_q ? out_q.instr : NOP_INSTR;
    assign decode_execute_opcode      = out_q.opcode;
    assign decode_execute_rd          = out_q.rd;
    assign decode_execute_rs1         = out_q.rs1;
    assign decode_execute_rs2         = out_q.rs2;
    assign decode_execute_funct3      = out_q.funct3;
    assign decode_execute_funct7      = out_q.funct7;
    assign decode_execute_imm         = out_q.imm;
    assign decode_execute_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed self-checking bench for decode_stage: reset state, immediate
//   formats and field extraction, illegal encodings, backpressure through the
//   skid buffer, flush, and asynchronous reset in mid-stream.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_imm;
    logic        ex_illegal;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .ifetch_decode_valid        (if_valid),
        .ifetch_decode_ready        (if_ready),
        .ifetch_decode_pc           (if_pc),
        .ifetch_decode_instruction  (if_instr),
        .writeback_decode_flush     (flush),
        .decode_execute_valid       (ex_valid),
        .decode_execute_ready       (ex_ready),
        .decode_execute_pc          (ex_pc),
        .decode_execute_instruction (ex_instr),
        .decode_execute_opcode      (ex_opcode),
        .decode_execute_rd          (ex_rd),
        .decode_execute_rs1         (ex_rs1),
        .decode_execute_rs2         (ex_rs2),
        .decode_execute_funct3      (ex_funct3),
        .decode_execute_funct7      (ex_funct7),
        .decode_execute_imm         (ex_imm),
        .decode_execute_illegal     (ex_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        total++; if (ex_instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr: got %h want 00000013", ex_instr); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
        total++; if (ex_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", ex_pc); end
        total++; if (ex_imm !== 32'h0) begin bad++; $display("FAIL reset_imm: got %h want 00000000", ex_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", ex_valid); end
    endtask

    // Back-to-back single beats through an unstalled stage; one row per word.
    task automatic test_decode_table();
        logic [31:0] t_instr [12];
        logic [6:0]  t_op    [12];
        logic [31:0] t_imm   [12];
        logic        t_ill   [12];
        t_instr[0]  = 32'h0050_0093; t_op[0]  = 7'h13; t_imm[0]  = 32'h0000_0005; t_ill[0]  = 1'b0; // addi x1,x0,5
        t_instr[1]  = 32'hFE00_0EE3; t_op[1]  = 7'h63; t_imm[1]  = 32'hFFFF_FFFC; t_ill[1]  = 1'b0; // beq -4
        t_instr[2]  = 32'h1234_50B7; t_op[2]  = 7'h37; t_imm[2]  = 32'h1234_5000; t_ill[2]  = 1'b0; // lui
        t_instr[3]  = 32'hFE20_AC23; t_op[3]  = 7'h23; t_imm[3]  = 32'hFFFF_FFF8; t_ill[3]  = 1'b0; // sw -8
        t_instr[4]  = 32'h0080_00EF; t_op[4]  = 7'h6F; t_imm[4]  = 32'h0000_0008; t_ill[4]  = 1'b0; // jal +8
        t_instr[5]  = 32'hFFF0_0093; t_op[5]  = 7'h13; t_imm[5]  = 32'hFFFF_FFFF; t_ill[5]  = 1'b0; // addi -1
        t_instr[6]  = 32'h0020_81B3; t_op[6]  = 7'h33; t_imm[6]  = 32'h0000_0000; t_ill[6]  = 1'b0; // add
        t_instr[7]  = 32'h0000_1017; t_op[7]  = 7'h17; t_imm[7]  = 32'h0000_1000; t_ill[7]  = 1'b0; // auipc
        t_instr[8]  = 32'h0000_0000; t_op[8]  = 7'h00; t_imm[8]  = 32'h0000_0000; t_ill[8]  = 1'b1;
        t_instr[9]  = 32'hFFFF_FFFF; t_op[9]  = 7'h7F; t_imm[9]  = 32'h0000_0000; t_ill[9]  = 1'b1;
        t_instr[10] = 32'h0000_000B; t_op[10] = 7'h0B; t_imm[10] = 32'h0000_0000; t_ill[10] = 1'b1; // custom-0
        t_instr[11] = 32'h8000_0067; t_op[11] = 7'h67; t_imm[11] = 32'hFFFF_F800; t_ill[11] = 1'b0; // jalr -2048
        ex_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if_valid = 1'b1;
            if_pc    = 32'h80 + 32'(4 * i);
            if_instr = t_instr[i];
            tick();
            total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL dec%0d_valid: got %b want 1", i, ex_valid); end
            total++; if (ex_pc !== 32'h80 + 32'(4 * i)) begin bad++; $display("FAIL dec%0d_pc: got %h want %h", i, ex_pc, 32'h80 + 32'(4 * i)); end
            total++; if (ex_instr !== t_instr[i]) begin bad++; $display("FAIL dec%0d_instr: got %h want %h", i, ex_instr, t_instr[i]); end
            total++; if (ex_opcode !== t_op[i]) begin bad++; $display("FAIL dec%0d_opcode: got %h want %h", i, ex_opcode, t_op[i]); end
            total++; if (ex_imm !== t_imm[i]) begin bad++; $display("FAIL dec%0d_imm: got %h want %h", i, ex_imm, t_imm[i]); end
            total++; if (ex_illegal !== t_ill[i]) begin bad++; $display("FAIL dec%0d_illegal: got %b want %b", i, ex_illegal, t_ill[i]); end
        end
        if_valid = 1'b0;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL dec_drain_valid: got %b want 0", ex_valid); end
        total++; if (ex_instr !== 32'h0000_0013) begin bad++; $display("FAIL dec_drain_nop: got %h want 00000013", ex_instr); end
    endtask

    task automatic test_fields();
        ex_ready = 1'b1;
        // addi x1,x0,5
        if_valid = 1'b1; if_pc = 32'h80; if_instr = 32'h0050_0093;
        tick();
        total++; if (ex_rd !== 5'd1) begin bad++; $display("FAIL addi_rd: got %0d want 1", ex_rd); end
        total++; if (ex_rs1 !== 5'd0) begin bad++; $display("FAIL addi_rs1: got %0d want 0", ex_rs1); end
        // sub x3,x1,x2
        if_instr = 32'h4020_81B3;
        tick();
        total++; if (ex_rd !== 5'd3) begin bad++; $display("FAIL sub_rd: got %0d want 3", ex_rd); end
        total++; if (ex_rs1 !== 5'd1) begin bad++; $display("FAIL sub_rs1: got %0d want 1", ex_rs1); end
        total++; if (ex_rs2 !== 5'd2) begin bad++; $display("FAIL sub_rs2: got %0d want 2", ex_rs2); end
        total++; if (ex_funct7 !== 7'h20) begin bad++; $display("FAIL sub_funct7: got %h want 20", ex_funct7); end
        total++; if (ex_funct3 !== 3'd0) begin bad++; $display("FAIL sub_funct3: got %0d want 0", ex_funct3); end
        // sw x2,-8(x1)
        if_instr = 32'hFE20_AC23;
        tick();
        total++; if (ex_funct3 !== 3'd2) begin bad++; $display("FAIL sw_funct3: got %0d want 2", ex_funct3); end
        total++; if (ex_rs1 !== 5'd1) begin bad++; $display("FAIL sw_rs1: got %0d want 1", ex_rs1); end
        total++; if (ex_rs2 !== 5'd2) begin bad++; $display("FAIL sw_rs2: got %0d want 2", ex_rs2); end
        if_valid = 1'b0;
        tick();
        total++; if (ex_rs2 !== 5'd2) begin bad++; $display("FAIL hold_rs2: got %0d want 2", ex_rs2); end
    endtask

    // Execute stalls for three edges while fetch streams pc 0,4,8.
    task automatic test_back_to_back();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'h0010_0093;
        tick();                                  // edge 1: pc0 -> out
        total++; if (ex_pc !== 32'h0 || ex_valid !== 1'b1) begin bad++; $display("FAIL bp_e1: got pc %h v %b want 00000000 v 1", ex_pc, ex_valid); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL bp_e1_ready: got %b want 1", if_ready); end
        if_pc = 32'h4; if_instr = 32'h0020_0093;
        tick();                                  // edge 2: pc4 -> skid
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL bp_e2_ready: got %b want 0", if_ready); end
        total++; if (ex_pc !== 32'h0) begin bad++; $display("FAIL bp_e2_pc: got %h want 00000000", ex_pc); end
        if_pc = 32'h8; if_instr = 32'h0030_0093;
        tick();                                  // edge 3: stalled, pc8 held by fetch
        total++; if (ex_pc !== 32'h0 || ex_instr !== 32'h0010_0093) begin bad++; $display("FAIL bp_e3_stable: got pc %h instr %h want 00000000 00100093", ex_pc, ex_instr); end
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL bp_e3_ready: got %b want 0", if_ready); end
        ex_ready = 1'b1;
        tick();                                  // edge 4: pc0 leaves, pc4 -> out
        total++; if (ex_pc !== 32'h4 || ex_valid !== 1'b1) begin bad++; $display("FAIL bp_e4: got pc %h v %b want 00000004 v 1", ex_pc, ex_valid); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL bp_e4_ready: got %b want 1", if_ready); end
        tick();                                  // edge 5: pc8 accepted straight into out
        total++; if (ex_pc !== 32'h8 || ex_valid !== 1'b1) begin bad++; $display("FAIL bp_e5: got pc %h v %b want 00000008 v 1", ex_pc, ex_valid); end
        if_valid = 1'b0;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL bp_e6_valid: got %b want 0", ex_valid); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h0050_0093;
        tick();
        if_pc = 32'h104;
        tick();                                  // both entries full
        total++; if (if_ready !== 1'b0 || ex_pc !== 32'h100) begin bad++; $display("FAIL fl_full: got ready %b pc %h want 0 00000100", if_ready, ex_pc); end
        if_pc = 32'h108; flush = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want 0", ex_valid); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL fl_ready: got %b want 1", if_ready); end
        total++; if (ex_instr !== 32'h0000_0013) begin bad++; $display("FAIL fl_nop: got %h want 00000013", ex_instr); end
        if_pc = 32'h10C;                         // accepted during flush, must be dropped
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_accept_drop: got %b want 0", ex_valid); end
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost%0d: got valid %b pc %h want 0", i, ex_valid, ex_pc); end
        end
        if_valid = 1'b1; if_pc = 32'h200; if_instr = 32'h0020_81B3;
        tick();
        if_valid = 1'b0;
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200) begin bad++; $display("FAIL fl_resume: got v %b pc %h want 1 00000200", ex_valid, ex_pc); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_resume_single: got %b want 0", ex_valid); end
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h300; if_instr = 32'h0050_0093;
        tick();
        if_valid = 1'b0;
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300) begin bad++; $display("FAIL ar_pre: got v %b pc %h want 1 00000300", ex_valid, ex_pc); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", ex_valid); end
        total++; if (ex_instr !== 32'h0000_0013) begin bad++; $display("FAIL ar_instr: got %h want 00000013", ex_instr); end
        total++; if (ex_pc !== 32'h0) begin bad++; $display("FAIL ar_pc: got %h want 00000000", ex_pc); end
        @(negedge clk);
        rst_n = 1'b1; ex_ready = 1'b1;
        if_valid = 1'b1; if_pc = 32'h400; if_instr = 32'h0050_0093;
        tick();
        if_valid = 1'b0;
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400) begin bad++; $display("FAIL ar_first: got v %b pc %h want 1 00000400", ex_valid, ex_pc); end
        total++; if (ex_imm !== 32'h5 || ex_rd !== 5'd1 || ex_illegal !== 1'b0) begin bad++; $display("FAIL ar_decode: got imm %h rd %0d ill %b want 00000005 1 0", ex_imm, ex_rd, ex_illegal); end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode_table();
        test_fields();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
